// File: rtl/sram_45x512_ctrl_if.sv
// Request/response handshake bus plus SRAM macro port 0 signals for the
// sram_45x512_ctrl block. The controller uses the slave modport; the
// requester/SRAM side uses the master modport.
interface sram_45x512_ctrl_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 6
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_we;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    logic                  sram_csb0;
    logic                  sram_web0;
    logic [ADDR_WIDTH-1:0] sram_addr0;
    logic [DATA_WIDTH-1:0] sram_din0;
    logic [DATA_WIDTH-1:0] sram_dout0;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_dout0,
        output req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata,
               sram_csb0, sram_web0, sram_addr0, sram_din0
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_dout0,
        input  req_ready, rsp_valid, rsp_we, rsp_err, rsp_rdata,
               sram_csb0, sram_web0, sram_addr0, sram_din0
    );
endinterface

// File: rtl/sram_45x512_ctrl.sv
// Controller for a 45-word x 512-bit single-port SRAM macro.
// Requests are issued to the macro one cycle after acceptance (p0 stage),
// the macro read data is captured one cycle later (p1 stage) and every
// request, in or out of range, lands in an in-order response FIFO with a
// fixed two-cycle latency. req_ready only admits a request when the FIFO
// has room for everything already in the pipeline plus the new one.
module sram_45x512_ctrl #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_WORDS  = 45,
    parameter int RSP_DEPTH  = 4
) (
    input  logic clk0,
    input  logic rstb0,
    sram_45x512_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Pipeline control (reset) and payload (not reset)
    logic                  r_vld_p0;
    logic                  r_vld_p1;
    logic                  r_we_p0;
    logic                  r_err_p0;
    logic                  r_we_p1;
    logic                  r_err_p1;

    // Response FIFO
    logic [CNT_W-1:0]      r_count;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic                  r_fifo_we   [RSP_DEPTH];
    logic                  r_fifo_err  [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [RSP_DEPTH];

    // SRAM drive registers
    logic                  r_csb;
    logic                  r_web;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;

    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rsp_valid;
    logic [CNT_W:0]        w_occupancy;
    logic [DATA_WIDTH-1:0] w_push_data;

    // Occupancy counts queued responses plus requests still in the pipeline,
    // so an admitted request is always guaranteed a FIFO slot on arrival.
    assign w_occupancy = (CNT_W+1)'(r_count) + (CNT_W+1)'(r_vld_p0) + (CNT_W+1)'(r_vld_p1);
    assign bus.req_ready = rstb0 && (w_occupancy < (CNT_W+1)'(RSP_DEPTH));
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_in_range    = ({1'b0, bus.req_addr} < (ADDR_WIDTH+1)'(NUM_WORDS));

    assign w_push      = r_vld_p1;
    assign w_rsp_valid = (r_count != '0);
    assign w_pop       = w_rsp_valid && bus.rsp_ready;
    // Only in-range reads carry SRAM data; writes and errors report zero.
    assign w_push_data = (!r_we_p1 && !r_err_p1) ? bus.sram_dout0 : '0;

    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_we     = w_rsp_valid && r_fifo_we[r_rd_ptr];
    assign bus.rsp_err    = w_rsp_valid && r_fifo_err[r_rd_ptr];
    assign bus.rsp_rdata  = w_rsp_valid ? r_fifo_data[r_rd_ptr] : '0;

    assign bus.sram_csb0  = r_csb;
    assign bus.sram_web0  = r_web;
    assign bus.sram_addr0 = r_addr;
    assign bus.sram_din0  = r_din;

    // Issue stage: drive the macro for exactly one cycle per in-range request.
    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            r_csb  <= 1'b1;
            r_web  <= 1'b1;
            r_addr <= '0;
            r_din  <= '0;
        end else if (w_accept && w_in_range) begin
            r_csb  <= 1'b0;
            r_web  <= !bus.req_we;
            r_addr <= bus.req_addr;
            r_din  <= bus.req_wdata;
        end else begin
            r_csb  <= 1'b1;
            r_web  <= 1'b1;
        end
    end

    // Pipeline valid bits: p0 = issued to SRAM, p1 = SRAM sampled, capture next.
    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p0 <= w_accept;
            r_vld_p1 <= r_vld_p0;
        end
    end

    // Pipeline payload travels alongside the valid bits; qualified by them.
    always_ff @(posedge clk0) begin
        r_we_p0  <= bus.req_we;
        r_err_p0 <= !w_in_range;
        r_we_p1  <= r_we_p0;
        r_err_p1 <= r_err_p0;
    end

    // FIFO pointers and count; power-of-two depth makes the pointers wrap.
    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: capture the response (and SRAM read data) at the p1 edge.
    always_ff @(posedge clk0) begin
        if (w_push) begin
            r_fifo_we[r_wr_ptr]   <= r_we_p1;
            r_fifo_err[r_wr_ptr]  <= r_err_p1;
            r_fifo_data[r_wr_ptr] <= w_push_data;
        end
    end
endmodule
